// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: shared types and constants for the exec_sequencer control slice
package exec_seq_pkg;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FREQ,
    ST_FWAIT,
    ST_DEC,
    ST_EXE,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int TO_W = 8;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  // states that wait on a memory response and are therefore timed
  function automatic logic is_wait_state(state_e s);
    return s inside {ST_FREQ, ST_FWAIT, ST_MEM};
  endfunction
  // states in which the core is doing work (not parked)
  function automatic logic is_active_state(state_e s);
    return !(s inside {ST_IDLE, ST_HALT, ST_ERR});
  endfunction
endpackage

// File: rtl/exec_seq_timeout.sv
// exec_seq_timeout: loadable saturating wait counter with clear, enable and expired flag
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : zero the count (highest priority after reset)
//   ld_i/ld_val_i: load an explicit count
//   en_i         : count one waited cycle
//   expired_o    : this enabled cycle is the LIMIT-th waited cycle
module exec_seq_timeout #(
  parameter int W = 8,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (ld_i) cnt_d = ld_val_i;
    else if (en_i && cnt_q != {W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // cnt_q holds the cycles already waited, so the current cycle is number cnt_q+1
  assign expired_o = en_i && (int'(cnt_q) + 1 >= LIMIT);
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/decode/execute/mem/write-back control FSM for the YPC core
//   start                         : leave IDLE and begin fetching
//   imem_req/addr/ready/rvalid/rdata : instruction fetch handshake, addr = pc
//   inst                          : instruction register driving the decoder
//   ebreak, wen, is_load, is_store, next_pc : decoder / execute results for inst
//   dmem_req/we/ack               : data access handshake
//   rf_wen                        : one-cycle register-file write strobe in WB
//   pc, halt, bus_err             : current PC, ebreak stop, sticky timeout/misalign error
// Optional: define EXEC_SEQ_PERF_EN to add 64-bit cycle_cnt and instret_cnt outputs.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEF),
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] inst,
  input  logic                  ebreak,
  input  logic                  wen,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ack,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  halt,
`ifdef EXEC_SEQ_PERF_EN
  output logic [63:0]           cycle_cnt,
  output logic [63:0]           instret_cnt,
`endif
  output logic                  bus_err
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, inst_q, inst_d;
  logic we_q, we_d, wen_q, wen_d;
  logic to_exp, misaligned;
  assign misaligned = |next_pc[1:0];
  exec_seq_timeout #(.W(TO_W), .LIMIT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .en_i     (is_wait_state(state_q)),
    .expired_o(to_exp)
  );
  // a response always beats a timeout expiring in the same cycle
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    we_d = we_q;
    wen_d = wen_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_FREQ : ST_IDLE;
      ST_FREQ: state_d = imem_ready ? ST_FWAIT : to_exp ? ST_ERR : ST_FREQ;
      ST_FWAIT: begin
        inst_d = imem_rvalid ? imem_rdata : inst_q;
        state_d = imem_rvalid ? ST_DEC : to_exp ? ST_ERR : ST_FWAIT;
      end
      ST_DEC: state_d = ST_EXE;
      ST_EXE: begin
        // decoder flags are captured so MEM/WB outputs depend on registers only
        we_d = is_store;
        wen_d = wen;
        state_d = ebreak ? ST_HALT : (is_load | is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: state_d = dmem_ack ? ST_WB : to_exp ? ST_ERR : ST_MEM;
      ST_WB: begin
        pc_d = misaligned ? pc_q : next_pc;
        state_d = misaligned ? ST_ERR : ST_FREQ;
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q <= RESET_PC;
      inst_q <= '0;
      we_q <= 1'b0;
      wen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      we_q <= we_d;
      wen_q <= wen_d;
    end
  end
  assign imem_req = state_q == ST_FREQ;
  assign imem_addr = pc_q;
  assign inst = inst_q;
  assign dmem_req = state_q == ST_MEM;
  assign dmem_we = dmem_req & we_q;
  assign rf_wen = (state_q == ST_WB) & wen_q;
  assign pc = pc_q;
  assign halt = state_q == ST_HALT;
  assign bus_err = state_q == ST_ERR;
`ifdef EXEC_SEQ_PERF_EN
  logic [63:0] cyc_q, ret_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= is_active_state(state_q) ? cyc_q + 64'd1 : cyc_q;
      ret_q <= (state_q == ST_WB && state_d == ST_FREQ) ? ret_q + 64'd1 : ret_q;
    end
  end
  assign cycle_cnt = cyc_q;
  assign instret_cnt = ret_q;
`endif
endmodule
